// File: rtl/riscv_v_cmp_mask_packer.sv
// riscv_v_cmp_mask_packer
// Collects the vector adder's per-element compare results. Each result is bit 0
// of the element's least significant byte. Beats are packed into a dense mask
// with one bit per element, which is handed to register-file writeback.
//
// Handshakes: every channel is valid/ready. A transfer happens on a rising clk
// edge where both valid and ready are high and flush is low. Ready never
// depends combinationally on valid. Once mask_valid is high, mask_data and
// mask_vl hold until mask_ready is seen or flush is asserted.
module riscv_v_cmp_mask_packer #(
  parameter int DATA_BYTES = 16,
  parameter int NUM_OSIZE  = 4,
  parameter int MAX_ELEMS  = 128
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           start_valid,
  output logic                           start_ready,
  input  logic [$clog2(MAX_ELEMS+1)-1:0] start_vl,
  input  logic [NUM_OSIZE-1:0]           start_osize_vector,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_BYTES*8-1:0]        in_result,
  output logic                           mask_valid,
  input  logic                           mask_ready,
  output logic [MAX_ELEMS-1:0]           mask_data,
  output logic [$clog2(MAX_ELEMS+1)-1:0] mask_vl
);

  localparam int VLW = $clog2(MAX_ELEMS + 1);
  localparam int OIW = (NUM_OSIZE > 1) ? $clog2(NUM_OSIZE) : 1;
  localparam int IW  = (MAX_ELEMS > 1) ? $clog2(MAX_ELEMS) : 1;
  // Wide enough to hold elem_cnt + one full beat without wrapping.
  localparam int CW  = $clog2(MAX_ELEMS + DATA_BYTES + 1);

  localparam logic [VLW-1:0] MAX_VL  = VLW'(MAX_ELEMS);
  localparam logic [CW-1:0]  MAX_CNT = CW'(MAX_ELEMS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_OUT     = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [VLW-1:0]        vl_q, vl_d;
  logic [OIW-1:0]        osize_q, osize_d;
  logic [VLW-1:0]        elem_cnt_q, elem_cnt_d;
  logic [MAX_ELEMS-1:0]  mask_data_q, mask_data_d;

  logic [OIW-1:0]        start_osize_idx;
  logic [VLW-1:0]        start_vl_clamped;
  logic [DATA_BYTES-1:0] ebits [NUM_OSIZE];
  logic [DATA_BYTES-1:0] beat_bits;
  logic [CW-1:0]         e_beat;
  logic [CW-1:0]         cnt_sum;
  logic                  last_beat;
  logic [CW-1:0]         pos;

  // Only one bit per element is meaningful; the remaining result bits are ignored.
  logic unused_result_bits;
  assign unused_result_bits = ^in_result;

  // Lowest set bit of the one-hot size selects the element size; all-zero means byte.
  always_comb begin
    start_osize_idx = '0;
    for (int i = NUM_OSIZE - 1; i >= 0; i--) begin
      if (start_osize_vector[i]) start_osize_idx = OIW'(i);
    end
  end

  assign start_vl_clamped = (start_vl > MAX_VL) ? MAX_VL : start_vl;

  // Extract the compare bit of every element for each possible element size.
  always_comb begin
    for (int o = 0; o < NUM_OSIZE; o++) begin
      ebits[o] = '0;
      for (int k = 0; k < (DATA_BYTES >> o); k++) begin
        ebits[o][k] = in_result[(k * 8) << o];
      end
    end
  end

  assign beat_bits = ebits[osize_q];
  assign e_beat    = CW'(DATA_BYTES) >> osize_q;
  assign cnt_sum   = CW'(elem_cnt_q) + e_beat;
  assign last_beat = cnt_sum >= CW'(vl_q);

  // Next-state logic: start latch, beat packing, mask handoff and flush abort.
  always_comb begin
    state_d     = state_q;
    vl_d        = vl_q;
    osize_d     = osize_q;
    elem_cnt_d  = elem_cnt_q;
    mask_data_d = mask_data_q;
    pos         = '0;

    case (state_q)
      S_IDLE: begin
        if (start_valid) begin
          vl_d        = start_vl_clamped;
          osize_d     = start_osize_idx;
          elem_cnt_d  = '0;
          mask_data_d = '0;
          state_d     = (start_vl_clamped == '0) ? S_OUT : S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (in_valid) begin
          // Elements past vl are never written, so tail bits stay zero.
          for (int k = 0; k < DATA_BYTES; k++) begin
            pos = CW'(elem_cnt_q) + CW'(k);
            if ((CW'(k) < e_beat) && (pos < CW'(vl_q))) begin
              mask_data_d[pos[IW-1:0]] = beat_bits[k];
            end
          end
          elem_cnt_d = (cnt_sum > MAX_CNT) ? MAX_VL : VLW'(cnt_sum);
          if (last_beat) state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (mask_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides every handshake in the same cycle.
    if (flush) begin
      state_d     = S_IDLE;
      elem_cnt_d  = '0;
      mask_data_d = '0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      vl_q        <= '0;
      osize_q     <= '0;
      elem_cnt_q  <= '0;
      mask_data_q <= '0;
    end else begin
      state_q     <= state_d;
      vl_q        <= vl_d;
      osize_q     <= osize_d;
      elem_cnt_q  <= elem_cnt_d;
      mask_data_q <= mask_data_d;
    end
  end

  // Handshake outputs decode directly from the registered state.
  assign start_ready = (state_q == S_IDLE);
  assign in_ready    = (state_q == S_COLLECT);
  assign mask_valid  = (state_q == S_OUT);
  assign mask_data   = mask_data_q;
  assign mask_vl     = vl_q;

endmodule

// File: tb/tb_riscv_v_cmp_mask_packer.sv
// Testbench for riscv_v_cmp_mask_packer: directed scenarios plus a randomized
// sweep scored against a simple element-indexed reference model.
module tb_riscv_v_cmp_mask_packer;

  localparam int DB   = 16;
  localparam int MAXE = 128;
  localparam int VLW  = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, flush;
  logic             start_valid, start_ready;
  logic [VLW-1:0]   start_vl;
  logic [3:0]       start_osize_vector;
  logic             in_valid, in_ready;
  logic [DB*8-1:0]  in_result;
  logic             mask_valid, mask_ready;
  logic [MAXE-1:0]  mask_data;
  logic [VLW-1:0]   mask_vl;

  riscv_v_cmp_mask_packer #(.DATA_BYTES(DB), .NUM_OSIZE(4), .MAX_ELEMS(MAXE)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .start_valid(start_valid), .start_ready(start_ready),
    .start_vl(start_vl), .start_osize_vector(start_osize_vector),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .mask_valid(mask_valid), .mask_ready(mask_ready),
    .mask_data(mask_data), .mask_vl(mask_vl)
  );

  int checks = 0;
  int errors = 0;
  logic [MAXE-1:0] exp_q[$];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int osz_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic int beats_needed(input int vl, input int oidx);
    int vlc, e;
    vlc = (vl > MAXE) ? MAXE : vl;
    e = DB >> oidx;
    return (vlc + e - 1) / e;
  endfunction

  // Element i of the instruction lives in beat i/E, slot i%E, at bit slot*8*2^oidx.
  function automatic logic [MAXE-1:0] model_mask(input int vl, input int oidx, input logic [DB*8-1:0] beats[$]);
    logic [MAXE-1:0] m;
    int vlc, e, i;
    m = '0;
    vlc = (vl > MAXE) ? MAXE : vl;
    e = DB >> oidx;
    for (int b = 0; b < beats.size(); b++) begin
      for (int k = 0; k < e; k++) begin
        i = b * e + k;
        if (i < vlc) m[i] = ((beats[b] >> (k * 8 * (1 << oidx))) & 128'd1) != 0;
      end
    end
    return m;
  endfunction

  function automatic logic [DB*8-1:0] rand_beat();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Random noise everywhere except the element compare bits, which come from ev.
  function automatic logic [DB*8-1:0] make_beat(input int oidx, input logic [15:0] ev);
    logic [DB*8-1:0] b;
    b = rand_beat();
    for (int k = 0; k < (DB >> oidx); k++) b[(k * 8) << oidx] = ev[k];
    return b;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input int vl, input logic [3:0] ov);
    start_valid = 1'b1;
    start_vl = vl[VLW-1:0];
    start_osize_vector = ov;
    tick();
    start_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [DB*8-1:0] d, output bit acc);
    in_valid = 1'b1;
    in_result = d;
    acc = in_ready;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic consume();
    mask_ready = 1'b1;
    tick();
    mask_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; start_valid = 1'b0; start_vl = '0; start_osize_vector = '0;
    in_valid = 1'b1; in_result = rand_beat(); mask_ready = 1'b0;
    repeat (3) tick();
    in_valid = 1'b0;
    rst = 1'b0;
    tick();
    checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL reset_start_ready: got %b expected 1", start_ready); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++; if (mask_valid !== 1'b0) begin errors++; $display("FAIL reset_mask_valid: got %b expected 0", mask_valid); end
    checks++; if (mask_data !== '0) begin errors++; $display("FAIL reset_mask_data: got %h expected 0", mask_data); end
    checks++; if (mask_vl !== '0) begin errors++; $display("FAIL reset_mask_vl: got %0d expected 0", mask_vl); end
  endtask

  task automatic test_byte_pattern();
    bit a0, a1;
    logic [MAXE-1:0] exp;
    exp = {108'b0, 4'b1011, 16'hA5A5};
    drive_start(20, 4'b0001);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL byte_in_ready: got %b expected 1", in_ready); end
    send_beat(make_beat(0, 16'hA5A5), a0);
    send_beat(make_beat(0, {12'hFFF, 4'b1011}), a1);
    checks++; if ({a0, a1} !== 2'b11) begin errors++; $display("FAIL byte_accept: got %b expected 11", {a0, a1}); end
    checks++; if (mask_valid !== 1'b1) begin errors++; $display("FAIL byte_latency: mask_valid got %b expected 1", mask_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL byte_in_ready_out: got %b expected 0", in_ready); end
    checks++; if (mask_data !== exp) begin errors++; $display("FAIL byte_mask: got %h expected %h", mask_data, exp); end
    checks++; if (mask_vl !== 8'd20) begin errors++; $display("FAIL byte_vl: got %0d expected 20", mask_vl); end
    consume();
    checks++; if ({mask_valid, start_ready} !== 2'b01) begin errors++; $display("FAIL byte_release: got %b expected 01", {mask_valid, start_ready}); end
  endtask

  task automatic test_word32();
    bit a0, a1;
    drive_start(6, 4'b0100);
    send_beat(make_beat(2, 16'h0006), a0);
    send_beat(make_beat(2, 16'h000D), a1);
    checks++; if ({a0, a1, mask_valid} !== 3'b111) begin errors++; $display("FAIL w32_handshake: got %b expected 111", {a0, a1, mask_valid}); end
    checks++; if (mask_data !== 128'h16) begin errors++; $display("FAIL w32_mask: got %h expected 16", mask_data); end
    consume();
  endtask

  task automatic test_vl_zero();
    in_valid = 1'b1;
    in_result = {DB*8{1'b1}};
    drive_start(0, 4'b0001);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL vl0_in_ready: got %b expected 0", in_ready); end
    checks++; if (mask_valid !== 1'b1) begin errors++; $display("FAIL vl0_mask_valid: got %b expected 1", mask_valid); end
    checks++; if (mask_data !== '0) begin errors++; $display("FAIL vl0_mask: got %h expected 0", mask_data); end
    checks++; if (mask_vl !== '0) begin errors++; $display("FAIL vl0_vl: got %0d expected 0", mask_vl); end
    consume();
    in_valid = 1'b0;
    checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL vl0_idle: got %b expected 1", start_ready); end
  endtask

  task automatic test_backpressure();
    bit acc;
    logic [DB*8-1:0] bq[$];
    logic [MAXE-1:0] exp;
    bq.push_back(rand_beat());
    exp = model_mask(16, 0, bq);
    drive_start(16, 4'b0001);
    send_beat(bq[0], acc);
    start_valid = 1'b1; start_vl = 8'd5; start_osize_vector = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      checks++; if (mask_valid !== 1'b1 || start_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_ctl c%0d: valid/start_ready got %b%b expected 10", c, mask_valid, start_ready); end
      checks++; if (mask_data !== exp || mask_vl !== 8'd16) begin errors++; $display("FAIL bp_hold_data c%0d: got %h/%0d expected %h/16", c, mask_data, mask_vl, exp); end
      tick();
    end
    start_valid = 1'b0;
    consume();
    checks++; if ({mask_valid, start_ready} !== 2'b01) begin errors++; $display("FAIL bp_release: got %b expected 01", {mask_valid, start_ready}); end
  endtask

  task automatic test_flush();
    bit acc;
    drive_start(48, 4'b0001);
    send_beat({DB*8{1'b1}}, acc);
    flush = 1'b1; in_valid = 1'b1; in_result = {DB*8{1'b1}};
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if ({start_ready, in_ready, mask_valid} !== 3'b100) begin errors++; $display("FAIL flush_state: got %b expected 100", {start_ready, in_ready, mask_valid}); end
    checks++; if (mask_data !== '0) begin errors++; $display("FAIL flush_clear: got %h expected 0", mask_data); end
    drive_start(16, 4'b0001);
    send_beat(make_beat(0, 16'hFFFF), acc);
    checks++; if (mask_valid !== 1'b1 || mask_data !== 128'hFFFF) begin errors++; $display("FAIL flush_restart: got %b/%h expected 1/ffff", mask_valid, mask_data); end
    consume();
  endtask

  task automatic test_clamp();
    bit acc;
    int n;
    logic [DB*8-1:0] bq[$];
    logic [MAXE-1:0] exp;
    n = 0;
    drive_start(200, 4'b0001);
    checks++; if (mask_vl !== 8'd128) begin errors++; $display("FAIL clamp_vl: got %0d expected 128", mask_vl); end
    for (int c = 0; c < 20; c++) begin
      logic [DB*8-1:0] b;
      if (in_ready !== 1'b1) break;
      b = rand_beat();
      send_beat(b, acc);
      if (acc) begin n++; bq.push_back(b); end
    end
    exp = model_mask(200, 0, bq);
    checks++; if (n != 8) begin errors++; $display("FAIL clamp_beats: got %0d expected 8", n); end
    checks++; if (mask_valid !== 1'b1 || mask_data !== exp) begin errors++; $display("FAIL clamp_mask: got %b/%h expected 1/%h", mask_valid, mask_data, exp); end
    consume();
  endtask

  task automatic test_random_back_to_back();
    for (int it = 0; it < 40; it++) begin
      int vl, oidx, need, acc_n, cyc, dly;
      logic [3:0] ov;
      logic [DB*8-1:0] bq[$];
      logic [MAXE-1:0] exp;
      bit vld, rdy;
      vl = ($urandom_range(0, 3) == 0) ? $urandom_range(129, 255) : $urandom_range(0, 128);
      ov = 4'($urandom_range(0, 15));
      oidx = osz_idx(ov);
      need = beats_needed(vl, oidx);
      checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL rnd_start_ready it%0d: got %b expected 1", it, start_ready); end
      drive_start(vl, ov);
      acc_n = 0; cyc = 0;
      while (acc_n < need && cyc < 200) begin
        vld = (it % 2 == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
        if (vld) begin
          logic [DB*8-1:0] b;
          b = rand_beat();
          send_beat(b, rdy);
          if (rdy) begin acc_n++; bq.push_back(b); end
        end else begin
          tick();
        end
        cyc++;
      end
      if (cyc >= 200) begin checks++; errors++; $display("FAIL rnd_timeout it%0d: accepted %0d expected %0d", it, acc_n, need); end
      exp_q.push_back(model_mask(vl, oidx, bq));
      checks++; if ({mask_valid, in_ready} !== 2'b10) begin errors++; $display("FAIL rnd_latency it%0d: valid/in_ready got %b%b expected 10", it, mask_valid, in_ready); end
      dly = $urandom_range(0, 3);
      repeat (dly) tick();
      exp = exp_q.pop_front();
      checks++; if (mask_data !== exp) begin errors++; $display("FAIL rnd_mask it%0d: got %h expected %h", it, mask_data, exp); end
      checks++; if (mask_vl !== VLW'((vl > MAXE) ? MAXE : vl)) begin errors++; $display("FAIL rnd_vl it%0d: got %0d expected %0d", it, mask_vl, (vl > MAXE) ? MAXE : vl); end
      consume();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_byte_pattern();
    test_word32();
    test_vl_zero();
    test_backpressure();
    test_flush();
    test_clamp();
    test_random_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
